// File: rtl/dispense_scheduler.sv
// Dispense demux sequencer: arbitrates A/B requests, drives sel/pulse, guard, ack.
// Define DISPENSE_RR_EN for round-robin arbitration; default is fixed priority to A.
module dispense_scheduler #(
    parameter int PULSE_CYCLES = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic stock_a,
    input  logic stock_b,
    output logic sel,
    output logic pulse,
    output logic ack_a,
    output logic ack_b,
    output logic busy
);

    if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_bad_pulse
        $error("dispense_scheduler: PULSE_CYCLES must be 1..255");
    end
    if (GUARD_CYCLES < 0 || GUARD_CYCLES > 255) begin : g_bad_guard
        $error("dispense_scheduler: GUARD_CYCLES must be 0..255");
    end

    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES);
    localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, GUARD, ACK} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       sel_nxt;
    logic       va, vb, win_a;

    assign va = req_a & stock_a;
    assign vb = req_b & stock_b;

`ifdef DISPENSE_RR_EN
    logic last_a;  // 1 when the previous completed grant went to A

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_a <= 1'b0;
        end else if (state == ACK) begin
            last_a <= sel;
        end
    end

    assign win_a = va & (~vb | ~last_a);
`else
    assign win_a = va;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latches.
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (va | vb) begin
                    sel_nxt   = win_a;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cnt_nxt   = PULSE_LD;
                state_nxt = PULSE;
            end
            PULSE: begin
                cnt_nxt = cnt - 8'd1;
                if (cnt_nxt == 8'd0) begin
                    if (GUARD_CYCLES == 0) begin
                        state_nxt = ACK;
                    end else begin
                        cnt_nxt   = GUARD_LD;
                        state_nxt = GUARD;
                    end
                end
            end
            GUARD: begin
                cnt_nxt = cnt - 8'd1;
                if (cnt_nxt == 8'd0) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for all sequential state.
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            sel   <= 1'b0;
            pulse <= 1'b0;
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            pulse <= (state_nxt == PULSE);
            ack_a <= (state_nxt == ACK) & sel_nxt;
            ack_b <= (state_nxt == ACK) & ~sel_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_dispense_scheduler.sv
// Randomized and directed bench for dispense_scheduler against a transaction-level model.
// Honours DISPENSE_RR_EN the same way as the design.
module tb_dispense_scheduler;

    localparam int P = 4;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_a = 1'b0, req_b = 1'b0, stock_a = 1'b0, stock_b = 1'b0;
    logic sel, pulse, ack_a, ack_b, busy;
    logic req2_a = 1'b0, stock2_a = 1'b0;
    logic sel2, pulse2, ack2_a, ack2_b, busy2;

    always #5 clk = ~clk;

    dispense_scheduler #(.PULSE_CYCLES(P), .GUARD_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .stock_a(stock_a), .stock_b(stock_b), .sel(sel), .pulse(pulse),
        .ack_a(ack_a), .ack_b(ack_b), .busy(busy)
    );

    dispense_scheduler #(.PULSE_CYCLES(1), .GUARD_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .req_a(req2_a), .req_b(1'b0),
        .stock_a(stock2_a), .stock_b(1'b0), .sel(sel2), .pulse(pulse2),
        .ack_a(ack2_a), .ack_b(ack2_b), .busy(busy2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Transaction model: a grant at edge g gives setup in interval g, pulse in
    // g+1..g+P, guard afterwards, ack in g+P+G+1, next grant no sooner than g+P+G+3.
    int k = 0, g = 0, free_edge = 1;
    bit have = 0, win_a_m = 0, sel_m = 0, last_a_m = 0;
    int pcount = 0, acka_cnt = 0, ackb_cnt = 0, busy_cnt = 0;

    function automatic bit exp_busy();
        return have && k >= g && k <= g + P + G + 1;
    endfunction
    function automatic bit exp_pulse();
        return have && k >= g + 1 && k <= g + P;
    endfunction
    function automatic bit exp_acka();
        return have && k == g + P + G + 1 && win_a_m;
    endfunction
    function automatic bit exp_ackb();
        return have && k == g + P + G + 1 && !win_a_m;
    endfunction

    task automatic model_edge();
        bit va, vb;
        va = req_a && stock_a;
        vb = req_b && stock_b;
        if (!rst && k >= free_edge && (va || vb)) begin
`ifdef DISPENSE_RR_EN
            win_a_m = (va && vb) ? !last_a_m : va;
`else
            win_a_m = va;
`endif
            have      = 1;
            g         = k;
            sel_m     = win_a_m;
            last_a_m  = win_a_m;
            free_edge = k + P + G + 3;
        end
    endtask

    task automatic model_reset();
        have = 0; sel_m = 0; last_a_m = 0; free_edge = k + 1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".busy"},  busy,  exp_busy());
        check({tag, ".pulse"}, pulse, exp_pulse());
        check({tag, ".ack_a"}, ack_a, exp_acka());
        check({tag, ".ack_b"}, ack_b, exp_ackb());
        check({tag, ".sel"},   sel,   sel_m);
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        model_edge();
        @(negedge clk);
        check_outputs($sformatf("cyc%0d", k));
        if (pulse === 1'b1) pcount++;
        if (ack_a === 1'b1) acka_cnt++;
        if (ack_b === 1'b1) ackb_cnt++;
        if (busy  === 1'b1) busy_cnt++;
    endtask

    // Requester obeys the handshake: drops its request in the ack cycle.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (exp_acka()) req_a = 1'b0;
            if (exp_ackb()) req_b = 1'b0;
        end
    endtask

    bit ack_seq[$];
    bit found;

    initial begin
        repeat (2) @(negedge clk);
        check_outputs("reset");
        check("reset.pulse2", pulse2, 1'b0);
        rst = 1'b0;
        model_reset();

        // Single A request
        req_a = 1; stock_a = 1; pcount = 0; acka_cnt = 0;
        run(12);
        check("t1.pulse_len", pcount, P);
        check("t1.ack_cnt", acka_cnt, 1);

        // Out-of-stock B is ignored, then served once stocked
        req_b = 1; stock_b = 0; busy_cnt = 0; ackb_cnt = 0;
        run(20);
        check("t2.busy_while_nostock", busy_cnt, 0);
        stock_b = 1;
        step();
        check("t2.grant_after_stock", busy, 1'b1);
        run(10);
        check("t2.ack_cnt", ackb_cnt, 1);

        // Both held through three transactions
        req_a = 1; req_b = 1; stock_a = 1; stock_b = 1;
        ack_seq.delete();
        for (int i = 0; i < 3 * (P + G + 3); i++) begin
            step();
            if (ack_a === 1'b1) ack_seq.push_back(1'b1);
            if (ack_b === 1'b1) ack_seq.push_back(1'b0);
        end
        req_a = 0; req_b = 0;
        check("t3.ack_count", ack_seq.size(), 3);
        if (ack_seq.size() == 3) begin
            check("t3.ack0_is_a", ack_seq[0], 1'b1);
`ifdef DISPENSE_RR_EN
            check("t3.ack1_is_a", ack_seq[1], 1'b0);
`else
            check("t3.ack1_is_a", ack_seq[1], 1'b1);
`endif
            check("t3.ack2_is_a", ack_seq[2], 1'b1);
        end
        run(10);

        // Request dropped in the second pulse cycle
        req_a = 1; pcount = 0; acka_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (have && k == g + 2) req_a = 0;
            if (exp_acka()) req_a = 0;
        end
        check("t4.pulse_len", pcount, P);
        check("t4.ack_cnt", acka_cnt, 1);

        // Reset during the pulse
        req_b = 1; stock_b = 1; found = 0; ackb_cnt = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (have && k == g + 2) found = 1;
        end
        check("t5.reached_pulse", found, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t5.pulse_async", pulse, 1'b0);
        check("t5.busy_async", busy, 1'b0);
        have = 0; sel_m = 0;
        step();
        step();
        rst = 1'b0;
        model_reset();
        run(12);
        check("t5.ack_after_reset", ackb_cnt, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step();
            if (exp_acka()) req_a = 0;
            else if (!req_a && $urandom_range(3) == 0) req_a = 1;
            else if (req_a && $urandom_range(15) == 0) req_a = 0;
            if (exp_ackb()) req_b = 0;
            else if (!req_b && $urandom_range(3) == 0) req_b = 1;
            else if (req_b && $urandom_range(15) == 0) req_b = 0;
            if ($urandom_range(7) == 0) stock_a = ~stock_a;
            if ($urandom_range(7) == 0) stock_b = ~stock_b;
        end
        req_a = 0; req_b = 0;
        run(12);

        // Minimum configuration: one pulse cycle, no guard
        req2_a = 1; stock2_a = 1;
        step();
        check("t6.setup.busy", busy2, 1'b1);
        check("t6.setup.pulse", pulse2, 1'b0);
        check("t6.setup.sel", sel2, 1'b1);
        step();
        check("t6.pulse.pulse", pulse2, 1'b1);
        check("t6.pulse.sel", sel2, 1'b1);
        check("t6.pulse.ack", ack2_a, 1'b0);
        step();
        check("t6.ack.pulse", pulse2, 1'b0);
        check("t6.ack.ack", ack2_a, 1'b1);
        check("t6.ack.sel", sel2, 1'b1);
        req2_a = 0;
        step();
        check("t6.idle.busy", busy2, 1'b0);
        check("t6.idle.ack", ack2_a, 1'b0);
        check("t6.idle.sel", sel2, 1'b1);
        check("t6.idle.ack_b", ack2_b, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
